uart_tx_byte_feeder: RTL and testbench



---
 rtl/uart_tx_byte_feeder.sv | 149 ++++++++++++++
 tb/tb_uart_tx_byte_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_byte_feeder.sv
// Byte FIFO plus sequencer feeding the UART transmit controller one byte at a time.
// Optional macro UART_TX_FEEDER_LEVEL_EN adds o_Level and o_Almost_Full.
module uart_tx_byte_feeder #(
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int ACTIVE_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Wr_En,
  input  logic [7:0] i_Wr_Data,
  output logic       o_Full,
  output logic       o_Empty,
  output logic       o_Overflow,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Tx_Ready,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic       o_Busy
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] o_Level,
  output logic                        o_Almost_Full
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACTIVE, WAIT_DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_next;
  logic [15:0]      timeout_cnt;
  logic [SYNC_STAGES-1:0] active_sync, done_sync;
  logic             done_prev;
  logic             active_s, done_rise;
  logic             pop, push;
  logic             ready_next, clr_timeout, inc_timeout;

  assign o_Full  = (count == CW'(FIFO_DEPTH));
  assign o_Empty = (count == '0);
  assign o_Busy  = (state != IDLE);

  // A pop in the same cycle frees a slot, so a write while full is still taken.
  assign pop  = (state == IDLE) && !o_Empty;
  assign push = i_Wr_En && (!o_Full || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_Wr_Data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
      o_Tx_Byte  <= 8'h00;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_Tx_Byte <= mem[rd_ptr];
      end
      if (i_Wr_En && !push) o_Overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_sync <= '0;
      done_sync   <= '0;
      done_prev   <= 1'b0;
    end else begin
      active_sync <= {active_sync[SYNC_STAGES-2:0], i_Tx_Active};
      done_sync   <= {done_sync[SYNC_STAGES-2:0], i_Tx_Done};
      done_prev   <= done_sync[SYNC_STAGES-1];
    end
  end

  assign active_s  = active_sync[SYNC_STAGES-1];
  assign done_rise = done_sync[SYNC_STAGES-1] && !done_prev;

  // Handshake: o_Tx_Ready is a level request; o_Tx_Byte stays stable while it is
  // high and until the synchronised Done edge ends the frame.
  always_comb begin
    state_next  = state;
    ready_next  = 1'b0;
    clr_timeout = 1'b0;
    inc_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (pop) state_next = LOAD;
      end
      LOAD: begin
        state_next  = WAIT_ACTIVE;
        ready_next  = 1'b1;
        clr_timeout = 1'b1;
      end
      WAIT_ACTIVE: begin
        if (active_s) begin
          state_next = WAIT_DONE;
        end else if (timeout_cnt == 16'(ACTIVE_TIMEOUT)) begin
          state_next = LOAD;
        end else begin
          ready_next  = 1'b1;
          inc_timeout = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      o_Tx_Ready  <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state      <= state_next;
      o_Tx_Ready <= ready_next;
      if (clr_timeout)      timeout_cnt <= '0;
      else if (inc_timeout) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

`ifdef UART_TX_FEEDER_LEVEL_EN
  assign o_Level = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_Almost_Full <= 1'b0;
    else       o_Almost_Full <= (count_next >= CW'(FIFO_DEPTH - 2));
  end
`endif

endmodule

// File: tb/tb_uart_tx_byte_feeder.sv
// Self-checking bench for uart_tx_byte_feeder: queue-based reference model compared
// every cycle, a reactive UART controller stand-in, and directed plus random tests.
module tb_uart_tx_byte_feeder;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int TMO   = 10;
  localparam int P_IDLE = 0, P_LOAD = 1, P_OFFER = 2, P_FRAME = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_active, tx_done;
  logic       o_full, o_empty, o_ovf, o_ready, o_busy;
  logic [7:0] o_byte;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [2:0] level;
  logic       almost_full;
`endif

  always #5 clk = ~clk;

  uart_tx_byte_feeder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .ACTIVE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst), .i_Wr_En(wr_en), .i_Wr_Data(wr_data),
    .o_Full(o_full), .o_Empty(o_empty), .o_Overflow(o_ovf),
    .o_Tx_Byte(o_byte), .o_Tx_Ready(o_ready),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(o_busy)
`ifdef UART_TX_FEEDER_LEVEL_EN
    , .o_Level(level), .o_Almost_Full(almost_full)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: byte queue, sticky overflow, and the offer/frame sequence
  logic [7:0] m_q[$];
  bit         m_ovf;
  logic [7:0] m_byte;
  int         m_phase;
  bit         m_ready;
  int         m_age;
  bit         a_h [1:SYNC+1];
  bit         d_h [1:SYNC+1];

  task automatic model_step();
    bit sa, drise, pop;
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_byte = 8'h00; m_phase = P_IDLE; m_ready = 0; m_age = 0;
      for (int k = 1; k <= SYNC + 1; k++) begin a_h[k] = 0; d_h[k] = 0; end
      return;
    end
    sa    = a_h[SYNC];
    drise = d_h[SYNC] && !d_h[SYNC+1];
    for (int k = SYNC + 1; k > 1; k--) begin a_h[k] = a_h[k-1]; d_h[k] = d_h[k-1]; end
    a_h[1] = tx_active;
    d_h[1] = tx_done;
    pop = (m_phase == P_IDLE) && (m_q.size() != 0);
    if (pop) begin
      m_byte  = m_q.pop_front();
      m_phase = P_LOAD;
    end else begin
      case (m_phase)
        P_LOAD:  begin m_phase = P_OFFER; m_ready = 1; m_age = 0; end
        P_OFFER: begin
          if (sa) begin m_phase = P_FRAME; m_ready = 0; end
          else if (m_age == TMO) begin m_phase = P_LOAD; m_ready = 0; end
          else m_age++;
        end
        P_FRAME: if (drise) m_phase = P_IDLE;
        default: ;
      endcase
    end
    if (wr_en) begin
      if (m_q.size() < DEPTH) m_q.push_back(wr_data);
      else m_ovf = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("full",  32'(o_full),  32'(m_q.size() == DEPTH));
    chk("empty", 32'(o_empty), 32'(m_q.size() == 0));
    chk("ovf",   32'(o_ovf),   32'(m_ovf));
    chk("ready", 32'(o_ready), 32'(m_ready));
    chk("busy",  32'(o_busy),  32'(m_phase != P_IDLE));
    chk("byte",  32'(o_byte),  32'(m_byte));
`ifdef UART_TX_FEEDER_LEVEL_EN
    chk("level", 32'(level), 32'(m_q.size()));
    chk("almost_full", 32'(almost_full), 32'(m_q.size() >= DEPTH - 2));
`endif
  end

  // Log of bytes taken for transmission (one entry per new frame)
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit busy_q = 0;
  initial forever begin
    @(negedge clk);
    if (o_busy && !busy_q) got_q.push_back(o_byte);
    busy_q = o_busy;
  end

  // UART controller stand-in
  int act_delay = 5, done_delay = 20, c_phase = 0, c_timer = 0, t_act = 0, t_done = 0;
  bit stall = 1, rand_delay = 0;
  initial begin
    tx_active = 0;
    tx_done   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        c_phase = 0; tx_active = 0; tx_done = 0;
      end else begin
        case (c_phase)
          0: if (o_ready && !stall) begin
               c_timer = rand_delay ? int'($urandom_range(0, 13)) : act_delay;
               c_phase = 1;
             end
          1: if (c_timer == 0) begin
               tx_active = 1; t_act = cyc;
               c_timer = rand_delay ? int'($urandom_range(4, 25)) : done_delay;
               c_phase = 2;
             end else c_timer--;
          2: if (c_timer == 0) begin
               tx_active = 0; tx_done = 1; t_done = cyc; c_timer = 1; c_phase = 3;
             end else c_timer--;
          3: if (c_timer == 0) begin tx_done = 0; c_phase = 0; end
             else c_timer--;
          default: c_phase = 0;
        endcase
      end
    end
  end

  task automatic do_reset();
    wr_en = 0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    got_q.delete();
  endtask

  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; wr_data = first + 8'(i);
      @(negedge clk);
    end
    wr_en = 0;
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == ph) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == P_IDLE && m_q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk(name, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog no_finish got=%0d exp=0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int diff;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_byte",  32'(o_byte),  32'h00);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_busy",  32'(o_busy),  32'd0);
    rst = 0;

    // Single byte with latency pins
    stall = 0; act_delay = 5; done_delay = 200;
    @(negedge clk);
    wr_en = 1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 0;
    @(negedge clk);
    chk("lat_ready_early", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("lat_ready_3clk", 32'(o_ready), 32'd1);
    chk("lat_byte", 32'(o_byte), 32'hA5);
    ok = 0;
    for (int i = 0; i < 40; i++) begin if (c_phase >= 2) begin ok = 1; break; end @(negedge clk); end
    chk("wait_active", 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin if (!o_ready) begin ok = 1; break; end @(negedge clk); end
    diff = cyc - t_act;
    chk("ready_drop_window", 32'(ok && diff >= 1 && diff <= SYNC + 1), 32'd1);
    ok = 0;
    for (int i = 0; i < 300; i++) begin if (c_phase == 3) begin ok = 1; break; end @(negedge clk); end
    chk("wait_done", 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin if (!o_busy) begin ok = 1; break; end @(negedge clk); end
    diff = cyc - t_done;
    chk("busy_fall_window", 32'(ok && diff >= 1 && diff <= SYNC + 2), 32'd1);

    // Burst order
    do_reset();
    act_delay = 3; done_delay = 15;
    burst(8'h01, 5);
    wait_drain(1000, "burst_drain");
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_log("burst_order");
    chk("burst_empty", 32'(o_empty), 32'd1);

    // Full and overflow with a stalled controller
    do_reset();
    stall = 1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_data = 8'hB0 + 8'(i);
      @(negedge clk);
      if (i == 4) begin
        chk("full_after_5", 32'(o_full), 32'd1);
        chk("no_ovf_after_5", 32'(o_ovf), 32'd0);
      end
    end
    wr_en = 0;
    chk("ovf_after_6", 32'(o_ovf), 32'd1);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", 32'(o_ovf), 32'd1);
    chk("stalled_byte", 32'(o_byte), 32'hB0);

    // Simultaneous write and pop while full
    do_reset();
    stall = 0; act_delay = 2; done_delay = 40;
    burst(8'h10, 1);
    wait_phase(P_FRAME, 50, "sim_frame");
    burst(8'h11, 4);
    chk("sim_full", 32'(o_full), 32'd1);
    wait_phase(P_IDLE, 100, "sim_idle");
    burst(8'h15, 1);
    chk("sim_still_full", 32'(o_full), 32'd1);
    chk("sim_no_ovf", 32'(o_ovf), 32'd0);
    wait_drain(2000, "sim_drain");
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    check_log("sim_order");

    // Timeout retry
    do_reset();
    stall = 1;
    burst(8'h3C, 1);
    ok = 0;
    for (int i = 0; i < 10; i++) begin if (o_ready) begin ok = 1; break; end @(negedge clk); end
    chk("tmo_first_ready", 32'(ok), 32'd1);
    for (int i = 0; i < 36; i++) begin
      chk("tmo_ready", 32'(o_ready), 32'((i % 12) != 11));
      chk("tmo_byte", 32'(o_byte), 32'h3C);
      @(negedge clk);
    end
    stall = 0;
    wait_drain(300, "tmo_drain");
    exp_q = '{8'h3C};
    check_log("tmo_log");

    // Asynchronous reset in the middle of a frame
    do_reset();
    act_delay = 2; done_delay = 60;
    burst(8'hA0, 4);
    wait_phase(P_FRAME, 50, "rst_frame");
    chk("rst_queued", 32'(m_q.size()), 32'd3);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_ready", 32'(o_ready), 32'd0);
    chk("async_busy",  32'(o_busy),  32'd0);
    chk("async_empty", 32'(o_empty), 32'd1);
    chk("async_full",  32'(o_full),  32'd0);
    chk("async_byte",  32'(o_byte),  32'h00);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(o_ready | o_busy), 32'd0);
    end
    burst(8'h9E, 1);
    wait_drain(300, "post_rst_drain");
    exp_q = '{8'hA0, 8'h9E};
    check_log("post_rst_log");

    // Randomized traffic
    do_reset();
    rand_delay = 1; stall = 0;
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_en = 0;
    wait_drain(5000, "rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
